// File: rtl/dtc_pkg.sv
// -----------------------------------------------------------------------------
// dtc_pkg
// Shared definitions for the digital-to-time converter (DTC) and its helpers.
//   - dtc_state_t : FSM state encoding (IDLE, ARMED, COUNT, PULSE)
//   - CODE_W / COARSE_* / FINE_* : layout of the 12-bit delay word
//   - dtc_code_t  : packed view of the delay word {coarse, fine}
//   - dtc_pack    : builds a delay word from its coarse and fine fields
// -----------------------------------------------------------------------------
package dtc_pkg;

  localparam int CODE_W     = 12;
  localparam int COARSE_MSB = 11;
  localparam int COARSE_LSB = 4;
  localparam int FINE_MSB   = 3;

  localparam int COARSE_W = COARSE_MSB - COARSE_LSB + 1;
  localparam int FINE_W   = FINE_MSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_PULSE = 2'd3
  } dtc_state_t;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } dtc_code_t;

  function automatic logic [CODE_W-1:0] dtc_pack(input logic [COARSE_W-1:0] coarse,
                                                 input logic [FINE_W-1:0]   fine);
    dtc_code_t w_word;
    w_word.coarse = coarse;
    w_word.fine   = fine;
    return w_word;
  endfunction

endpackage

// File: rtl/dtc_edge_detect.sv
// -----------------------------------------------------------------------------
// dtc_edge_detect
// Rising-edge detector for a signal that is already synchronous to clk.
// Shared between the DTC trigger input and the TDC front end.
//
// Ports:
//   clk      input   system clock
//   reset_n  input   asynchronous active-low reset (history register -> 0)
//   i_sig    input   synchronous level to watch
//   o_rise   output  high for the one cycle in which i_sig is high and was
//                    low in the previous cycle
// -----------------------------------------------------------------------------
module dtc_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig_d1 <= 1'b0;
    end else begin
      r_sig_d1 <= i_sig;
    end
  end

  // Combinational strobe so the FSM can act in the same cycle the edge appears.
  assign o_rise = i_sig & ~r_sig_d1;

endmodule

// File: rtl/digital_to_time_converter.sv
// -----------------------------------------------------------------------------
// digital_to_time_converter
// Turns a delay word {coarse, fine} into a delayed one-shot edge. After a code
// is accepted the block arms; on the next trigger rising edge it waits
// max(coarse,1) clock cycles, then drives edge_out high for PULSE_W cycles with
// the latched fine tap presented on fine_sel for the external delay-line mux.
//
// Optional build macro:
//   DTC_AUTO_REARM_EN  when defined, PULSE returns to ARMED instead of IDLE and
//                      reuses the latched code; a code offered in the final
//                      PULSE cycle is accepted and replaces the latch.
//
// Ports:
//   clk         input   system clock
//   reset_n     input   asynchronous active-low reset
//   code        input   delay word; [11:4] coarse cycles, [3:0] fine tap
//   code_valid  input   code offered
//   code_ready  output  code can be accepted this cycle
//   trigger     input   synchronous reference event (rising edge starts timing)
//   edge_out    output  delayed edge, high for PULSE_W cycles
//   fine_sel    output  fine tap select, held between pulses
//   busy        output  high in ARMED, COUNT, PULSE
//   done        output  one-cycle pulse on the last PULSE cycle
//   overrun     output  sticky: trigger edge during COUNT/PULSE; cleared by
//                       the next accepted code
// -----------------------------------------------------------------------------
module digital_to_time_converter
  import dtc_pkg::*;
#(
  parameter int COARSE_BITS = COARSE_W,
  parameter int FINE_BITS   = FINE_W,
  parameter int PULSE_W     = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [COARSE_BITS+FINE_BITS-1:0] code,
  input  logic                             code_valid,
  output logic                             code_ready,
  input  logic                             trigger,
  output logic                             edge_out,
  output logic [FINE_BITS-1:0]             fine_sel,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);

  localparam int PCNT_W = 4;

  localparam logic [COARSE_BITS-1:0] C_ONE        = COARSE_BITS'(1);
  localparam logic [PCNT_W-1:0]      C_PCNT_ONE   = PCNT_W'(1);
  localparam logic [PCNT_W-1:0]      C_PULSE_LAST = PCNT_W'(PULSE_W - 1);

  dtc_state_t             r_state;
  logic [COARSE_BITS-1:0] r_coarse;
  logic [FINE_BITS-1:0]   r_fine;
  logic [COARSE_BITS-1:0] r_cnt;
  logic [PCNT_W-1:0]      r_pcnt;
  logic                   r_edge_out;
  logic [FINE_BITS-1:0]   r_fine_sel;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;

  logic                   w_rise;
  logic                   w_pulse_last;
  logic                   w_code_ready;
  logic                   w_accept;
  logic [COARSE_BITS-1:0] w_load;

  dtc_edge_detect u_trig_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sig   (trigger),
    .o_rise  (w_rise)
  );

  assign w_pulse_last = (r_state == ST_PULSE) && (r_pcnt == '0);

`ifdef DTC_AUTO_REARM_EN
  assign w_code_ready = (r_state == ST_IDLE) || w_pulse_last;
`else
  assign w_code_ready = (r_state == ST_IDLE);
`endif

  assign w_accept = code_valid & w_code_ready;

  // Remaining COUNT cycles once the edge is seen. Coarse 0 and 1 both need no
  // COUNT cycle: the edge is detected in the ARMED cycle and edge_out rises on
  // the next one.
  assign w_load = (r_coarse == '0) ? '0 : (r_coarse - C_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_coarse   <= '0;
      r_fine     <= '0;
      r_cnt      <= '0;
      r_pcnt     <= '0;
      r_edge_out <= 1'b0;
      r_fine_sel <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Trigger edges here are deliberately ignored.
          if (w_accept) begin
            r_coarse  <= code[COARSE_BITS+FINE_BITS-1:FINE_BITS];
            r_fine    <= code[FINE_BITS-1:0];
            r_overrun <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (w_rise) begin
            if (w_load == '0) begin
              r_state    <= ST_PULSE;
              r_edge_out <= 1'b1;
              r_fine_sel <= r_fine;
              r_pcnt     <= C_PULSE_LAST;
              r_done     <= (C_PULSE_LAST == '0);
            end else begin
              r_cnt   <= w_load;
              r_state <= ST_COUNT;
            end
          end
        end

        ST_COUNT: begin
          if (w_rise) begin
            r_overrun <= 1'b1;
          end
          // Leaving on the decrement to zero keeps the rise at exactly
          // coarse cycles after detection; the counter never wraps.
          if (r_cnt == C_ONE) begin
            r_cnt      <= '0;
            r_state    <= ST_PULSE;
            r_edge_out <= 1'b1;
            r_fine_sel <= r_fine;
            r_pcnt     <= C_PULSE_LAST;
            r_done     <= (C_PULSE_LAST == '0);
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        ST_PULSE: begin
          if (w_rise) begin
            r_overrun <= 1'b1;
          end
          if (r_pcnt == '0) begin
            // fine_sel is left untouched so the mux input stays quiet.
            r_edge_out <= 1'b0;
            r_done     <= 1'b0;
`ifdef DTC_AUTO_REARM_EN
            r_state <= ST_ARMED;
            if (w_accept) begin
              r_coarse  <= code[COARSE_BITS+FINE_BITS-1:FINE_BITS];
              r_fine    <= code[FINE_BITS-1:0];
              r_overrun <= 1'b0;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_pcnt <= r_pcnt - C_PCNT_ONE;
            r_done <= (r_pcnt == C_PCNT_ONE);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign code_ready = w_code_ready;
  assign edge_out   = r_edge_out;
  assign fine_sel   = r_fine_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_digital_to_time_converter.sv
// -----------------------------------------------------------------------------
// tb_digital_to_time_converter
// Self-checking bench. The reference model is a timeline: a trigger edge in
// cycle 0 gives edge_out in cycles d..d+PW-1 with d = max(coarse,1), done in
// the last of those, and the block idle (or re-armed) afterwards.
// -----------------------------------------------------------------------------
module tb_digital_to_time_converter;
  import dtc_pkg::*;

  localparam int PW = 2;
`ifdef DTC_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [11:0] code       = '0;
  logic        code_valid = 1'b0;
  logic        trigger    = 1'b0;
  logic        code_ready;
  logic        edge_out;
  logic [3:0]  fine_sel;
  logic        busy;
  logic        done;
  logic        overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic       exp_ovr  = 1'b0;
  logic [3:0] exp_fine = 4'h0;

  always #5 clk = ~clk;

  digital_to_time_converter #(
    .COARSE_BITS (8),
    .FINE_BITS   (4),
    .PULSE_W     (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .trigger    (trigger),
    .edge_out   (edge_out),
    .fine_sel   (fine_sel),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_cycle(input string tag, input bit e_edge, input bit e_busy, input bit e_done);
    check_eq({tag, ".edge_out"},   32'(edge_out),   32'(e_edge));
    check_eq({tag, ".busy"},       32'(busy),       32'(e_busy));
    check_eq({tag, ".done"},       32'(done),       32'(e_done));
    check_eq({tag, ".code_ready"}, 32'(code_ready), 32'((!e_busy) || (REARM && e_done)));
    check_eq({tag, ".fine_sel"},   32'(fine_sel),   32'(exp_fine));
    check_eq({tag, ".overrun"},    32'(overrun),    32'(exp_ovr));
  endtask

  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    exp_ovr  = 1'b0;
    exp_fine = 4'h0;
    #1;
    check_cycle({tag, ".rst_async"}, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_cycle({tag, ".rst_hold"}, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
  endtask

  // One code / one trigger transaction. retrig > 0 re-raises trigger in that
  // cycle after detection, which must set overrun without moving the pulse.
  task automatic run_txn(input logic [11:0] c, input int pre, input int retrig);
    int d;
    d = (c[11:4] == 8'h00) ? 1 : int'(c[11:4]);
    $display("txn cycle=%0d code=0x%03h delay=%0d pre=%0d retrig=%0d", cyc, c, d, pre, retrig);
    check_cycle("idle", 1'b0, 1'b0, 1'b0);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    code       = 12'($urandom);
    exp_ovr    = 1'b0;
    check_cycle("armed", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < pre; k++) begin
      step();
      check_cycle("armed_wait", 1'b0, 1'b1, 1'b0);
    end
    trigger = 1'b1;
    for (int i = 1; i <= d + PW; i++) begin
      step();
      if (retrig > 0 && i == retrig + 1) exp_ovr = 1'b1;
      if (i == d) exp_fine = c[3:0];
      check_cycle("run", (i >= d) && (i < d + PW), REARM || (i < d + PW), i == d + PW - 1);
      if (i == 1) trigger = 1'b0;
      if (retrig > 0 && i == retrig) trigger = 1'b1;
    end
    trigger = 1'b0;
    step();
    check_cycle("after", 1'b0, REARM, 1'b0);
    if (REARM) begin
      do_reset("rearm_clr");
    end else begin
      // A trigger edge while idle produces nothing and leaves overrun alone.
      trigger = 1'b1;
      step();
      check_cycle("idle_trig", 1'b0, 1'b0, 1'b0);
      trigger = 1'b0;
      step();
      check_cycle("idle_trig_low", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_mid(input logic [11:0] c, input int at, input bit e_edge);
    $display("txn cycle=%0d reset_mid code=0x%03h at=%0d", cyc, c, at);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    trigger    = 1'b1;
    for (int i = 1; i <= at; i++) begin
      step();
      trigger = 1'b0;
    end
    check_eq("rm.edge_before", 32'(edge_out), 32'(e_edge));
    check_eq("rm.busy_before", 32'(busy), 32'(1));
    do_reset("rm");
    // Latched code is gone: a trigger now must not produce a pulse.
    trigger = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 3) trigger = 1'b0;
      check_cycle("rm_after", 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [11:0] rc;
    int          rt;

    reset_n = 1'b0;
    step();
    step();
    check_cycle("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    check_cycle("reset_rel", 1'b0, 1'b0, 1'b0);

    run_txn(dtc_pack(8'h05, 4'h3), 2, 0);
    run_txn(dtc_pack(8'h00, 4'hA), 0, 0);
    run_txn(dtc_pack(8'h01, 4'h6), 1, 0);
    run_txn(dtc_pack(8'hFF, 4'h0), 1, 0);
    run_txn(dtc_pack(8'h10, 4'h0), 3, 5);
    run_txn(dtc_pack(8'h03, 4'hC), 0, 4);

    for (int n = 0; n < 10; n++) begin
      rc = dtc_pack(8'($urandom_range(40, 0)), 4'($urandom));
      rt = 0;
      if ($urandom_range(1, 0) == 1) begin
        rt = $urandom_range(((rc[11:4] == 8'h00) ? 1 : int'(rc[11:4])) + PW - 1, 2);
      end
      run_txn(rc, $urandom_range(4, 0), rt);
    end

    reset_mid(dtc_pack(8'h10, 4'h7), 3, 1'b0);
    reset_mid(dtc_pack(8'h01, 4'h9), 1, 1'b1);

    // Periodic trigger, one code: every edge pulses only with auto re-arm.
    $display("txn cycle=%0d periodic code=0x025 rearm=%0d", cyc, REARM);
    code       = dtc_pack(8'h02, 4'h5);
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      trigger = 1'b1;
      for (int t = 1; t <= 20; t++) begin
        bit pulsing;
        step();
        pulsing = REARM || (k == 0);
        if (pulsing && t == 2) exp_fine = 4'h5;
        check_cycle("periodic", pulsing && (t == 2 || t == 3),
                    REARM || (k == 0 && t < 4), pulsing && (t == 3));
        if (t == 10) trigger = 1'b0;
      end
    end
    do_reset("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
